// File: rtl/mem_stage_pkg.sv
// Shared types and defaults for the memory-stage controller.
// Latency: n/a (types, constants and a width helper only).
// Backpressure: n/a.
package mem_stage_pkg;

    localparam int DW_DEF      = 16;
    localparam int TIMEOUT_DEF = 15;

    // Counter wide enough to hold the values 0..timeout.
    function automatic int cnt_width(input int timeout);
        return $clog2(timeout + 1);
    endfunction

    localparam int CNT_W_DEF = cnt_width(TIMEOUT_DEF);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_t;

endpackage

// File: rtl/mem_timeout_cnt.sv
// WAIT-phase cycle counter with a terminal-count flag.
// Latency: cnt updates one cycle after clr/en; tc is combinational from cnt.
// Backpressure: none; clr has priority over en.
//
// Ports: clk, rst (async, active-high), clr (sync clear), en (count enable),
//        tc (high during the TIMEOUT-th enabled cycle since the last clear).
module mem_timeout_cnt #(
    parameter int TIMEOUT = 15,
    parameter int CW      = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    // cnt holds the number of WAIT cycles already elapsed, so the current
    // cycle is the TIMEOUT-th one when cnt == TIMEOUT-1; the increment at
    // this edge is the one that reaches TIMEOUT.
    assign tc = (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: runs one X/M load/store against a stallable memory.
// Latency: best case 3 stall cycles (IDLE, ISSUE, WAIT) then a DONE cycle.
// Backpressure: mem_busy holds the request in ISSUE; stall_out holds the pipe.
//
// Ports: clk, rst (async, active-high), flush;
//        X/M side:    mem_read_in, mem_write_in, addr_in, wdata_in;
//        memory side: mem_en, mem_wr, mem_addr, mem_wdata, mem_busy, mem_done, mem_rdata;
//        pipe side:   stall_out, rdata_out, rdata_valid, err_out (sticky).
module mem_stage_ctrl
    import mem_stage_pkg::*;
#(
    parameter int DW      = DW_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          mem_read_in,
    input  logic          mem_write_in,
    input  logic [DW-1:0] addr_in,
    input  logic [DW-1:0] wdata_in,
    output logic          mem_en,
    output logic          mem_wr,
    output logic [DW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_busy,
    input  logic          mem_done,
    input  logic [DW-1:0] mem_rdata,
    output logic          stall_out,
    output logic [DW-1:0] rdata_out,
    output logic          rdata_valid,
    output logic          err_out
);

    localparam int CW = cnt_width(TIMEOUT);

    state_t        state;
    state_t        state_nxt;
    logic          req_wr;
    logic [DW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          flush_seen;
    logic          mem_req;
    logic          launch;
    logic          misalign;
    logic          accept;
    logic          cnt_tc;

    assign mem_req  = mem_read_in | mem_write_in;
    assign misalign = (state == IDLE) & mem_req & addr_in[0];
    assign launch   = (state == IDLE) & mem_req & ~flush & ~addr_in[0];
    assign accept   = (state == ISSUE) & ~mem_busy;

    // Request strobe is state-decoded; the rest comes straight from the
    // request registers, which stay stable for the whole access.
    assign mem_en    = (state == ISSUE);
    assign mem_wr    = req_wr;
    assign mem_addr  = req_addr;
    assign mem_wdata = req_wdata;

    mem_timeout_cnt #(
        .TIMEOUT (TIMEOUT),
        .CW      (CW)
    ) u_timeout_cnt (
        .clk (clk),
        .rst (rst),
        .clr (accept),
        .en  (state == WAIT),
        .tc  (cnt_tc)
    );

    always_comb begin
        state_nxt = state;
        stall_out = 1'b0;
        case (state)
            IDLE: begin
                if (launch) begin
                    stall_out = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (!mem_busy) begin
                    stall_out = 1'b1;
                    state_nxt = WAIT;
                end else if (flush) begin
                    // Not yet accepted by memory, so it can still be dropped.
                    state_nxt = IDLE;
                end else begin
                    stall_out = 1'b1;
                end
            end
            WAIT: begin
                stall_out = 1'b1;
                if (mem_done || cnt_tc) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            req_wr      <= 1'b0;
            req_addr    <= '0;
            req_wdata   <= '0;
            flush_seen  <= 1'b0;
            rdata_out   <= '0;
            rdata_valid <= 1'b0;
            err_out     <= 1'b0;
        end else begin
            state       <= state_nxt;
            rdata_valid <= 1'b0;
            if (launch) begin
                // Read+write together is treated as a write.
                req_wr     <= mem_write_in;
                req_addr   <= addr_in;
                req_wdata  <= wdata_in;
                flush_seen <= 1'b0;
            end
            if (state == WAIT) begin
                if (flush) begin
                    flush_seen <= 1'b1;
                end
                if (mem_done && !req_wr) begin
                    rdata_out   <= mem_rdata;
                    rdata_valid <= ~(flush_seen | flush);
                end
            end
            if (misalign || ((state == WAIT) && !mem_done && cnt_tc)) begin
                err_out <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Randomized scoreboard bench for mem_stage_ctrl with a memory emulator.
// Latency: n/a (testbench).
// Backpressure: emulated memory drives random mem_busy and mem_done delays.
module tb_mem_stage_ctrl;

    localparam int DW      = 16;
    localparam int TIMEOUT = 15;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic          mem_read_in = 1'b0;
    logic          mem_write_in = 1'b0;
    logic [DW-1:0] addr_in = '0;
    logic [DW-1:0] wdata_in = '0;
    logic          mem_en;
    logic          mem_wr;
    logic [DW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_busy = 1'b0;
    logic          mem_done = 1'b0;
    logic [DW-1:0] mem_rdata = '0;
    logic          stall_out;
    logic [DW-1:0] rdata_out;
    logic          rdata_valid;
    logic          err_out;

    mem_stage_ctrl #(.DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .mem_read_in  (mem_read_in),
        .mem_write_in (mem_write_in),
        .addr_in      (addr_in),
        .wdata_in     (wdata_in),
        .mem_en       (mem_en),
        .mem_wr       (mem_wr),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_busy     (mem_busy),
        .mem_done     (mem_done),
        .mem_rdata    (mem_rdata),
        .stall_out    (stall_out),
        .rdata_out    (rdata_out),
        .rdata_valid  (rdata_valid),
        .err_out      (err_out)
    );

    always #5 clk = ~clk;

    // Expected outcome of one stalled access, as seen at the cycle where
    // stall_out drops (DONE, or the ISSUE cycle that drops the request).
    typedef struct {
        int            stalls;
        int            en_cycles;
        bit            valid;
        logic [DW-1:0] rdata;
        bit            err;
        bit            wr;
        logic [DW-1:0] addr;
        logic [DW-1:0] wdata;
    } exp_t;

    exp_t          q[$];
    int            total = 0;
    int            bad = 0;
    logic [DW-1:0] m_rdata = '0;
    bit            m_err = 1'b0;
    bit            mon_en = 1'b0;
    bit            prev_stall = 1'b0;
    int            run_stall = 0;
    int            run_en = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, req, $time);
        end
    endtask

    task automatic clear_req();
        mem_read_in  = 1'b0;
        mem_write_in = 1'b0;
        addr_in      = '0;
        wdata_in     = '0;
    endtask

    // Monitor: counts stall/mem_en cycles of the running access and scores
    // it against the front of the queue when stall_out falls.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (stall_out) begin
                run_stall++;
                if (mem_en) begin
                    run_en++;
                    chk("req_pending", 32'(q.size() != 0), 32'd1);
                    if (q.size() != 0) begin
                        chk("mem_wr", 32'(mem_wr), 32'(q[0].wr));
                        chk("mem_addr", 32'(mem_addr), 32'(q[0].addr));
                        chk("mem_wdata", 32'(mem_wdata), 32'(q[0].wdata));
                    end
                end
                chk("rvalid_stall", 32'(rdata_valid), 32'd0);
            end else if (prev_stall) begin
                if (mem_en) run_en++;
                chk("evt_pending", 32'(q.size() != 0), 32'd1);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    chk("stall_cycles", 32'(run_stall), 32'(e.stalls));
                    chk("en_cycles", 32'(run_en), 32'(e.en_cycles));
                    chk("rdata_valid", 32'(rdata_valid), 32'(e.valid));
                    chk("rdata_out", 32'(rdata_out), 32'(e.rdata));
                    chk("err_out", 32'(err_out), 32'(e.err));
                end
                run_stall = 0;
                run_en    = 0;
            end else begin
                chk("mem_en_idle", 32'(mem_en), 32'd0);
                chk("rvalid_idle", 32'(rdata_valid), 32'd0);
            end
            prev_stall = stall_out;
        end
    end

    // Drives one X/M instruction plus the memory's reaction to it.
    // dly is the WAIT-cycle index (0-based) of mem_done; dly >= TIMEOUT means never.
    task automatic run_txn(input bit rd, input bit wr, input logic [DW-1:0] a,
                           input logic [DW-1:0] wd, input int nb, input int dly,
                           input bit fl_idle, input bit fl_issue, input bit fl_wait,
                           input logic [DW-1:0] rv);
        exp_t e;
        bit   tmo;
        int   w;
        mem_read_in  = rd;
        mem_write_in = wr;
        addr_in      = a;
        wdata_in     = wd;
        if (a[0] || fl_idle || !(rd || wr)) begin
            // No access issued: no stall; misaligned memory ops raise err.
            flush = fl_idle;
            @(negedge clk);
            chk("idle_nostall", 32'(stall_out), 32'd0);
            @(posedge clk);
            #1;
            if (a[0] && (rd || wr)) m_err = 1'b1;
            clear_req();
            flush = 1'b0;
            @(negedge clk);
            chk("idle_err", 32'(err_out), 32'(m_err));
            chk("idle_noreq", 32'(mem_en), 32'd0);
            @(posedge clk);
            #1;
            return;
        end
        e.wr    = wr;
        e.addr  = a;
        e.wdata = wd;
        if (fl_issue) begin
            e.stalls    = 1;
            e.en_cycles = 1;
            e.valid     = 1'b0;
            e.rdata     = m_rdata;
            e.err       = m_err;
            q.push_back(e);
            @(posedge clk);
            #1;
            mem_busy = 1'b1;
            flush    = 1'b1;
            @(posedge clk);
            #1;
            mem_busy = 1'b0;
            flush    = 1'b0;
            clear_req();
            return;
        end
        tmo         = (dly >= TIMEOUT);
        w           = tmo ? TIMEOUT : dly + 1;
        e.stalls    = 1 + nb + 1 + w;
        e.en_cycles = nb + 1;
        e.valid     = !wr && !tmo && !fl_wait;
        if (!wr && !tmo) m_rdata = rv;
        if (tmo) m_err = 1'b1;
        e.rdata     = m_rdata;
        e.err       = m_err;
        q.push_back(e);
        @(posedge clk);
        #1;
        repeat (nb) begin
            mem_busy = 1'b1;
            mem_done = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
        mem_busy = 1'b0;
        mem_done = 1'b0;
        @(posedge clk);
        #1;
        for (int j = 0; j < w; j++) begin
            flush = fl_wait && (j == 0);
            if (!tmo && j == dly) begin
                mem_done  = 1'b1;
                mem_rdata = rv;
            end else begin
                mem_done  = 1'b0;
                mem_rdata = DW'($urandom);
            end
            @(posedge clk);
            #1;
        end
        // DONE cycle: a stray completion pulse here must be ignored.
        flush     = 1'b0;
        mem_done  = 1'($urandom_range(0, 1));
        mem_rdata = DW'($urandom);
        clear_req();
        @(posedge clk);
        #1;
        mem_done = 1'b0;
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int kind;
        logic [DW-1:0] a;
        int nb;
        int dly;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_mem_wr", 32'(mem_wr), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_stall", 32'(stall_out), 32'd0);
        chk("rst_rdata", 32'(rdata_out), 32'd0);
        chk("rst_rvalid", 32'(rdata_valid), 32'd0);
        chk("rst_err", 32'(err_out), 32'd0);
        rst = 1'b0;
        mon_en = 1'b1;
        @(posedge clk);
        #1;

        //       rd wr addr      wdata     nb dly          fI fS fW rdata
        run_txn(1, 0, 16'h0010, 16'h0000, 0, 0,          0, 0, 0, 16'hBEEF);
        run_txn(0, 1, 16'h0020, 16'h1234, 2, 0,          0, 0, 0, 16'h0000);
        run_txn(1, 0, 16'h0024, 16'h0000, 0, TIMEOUT-1,  0, 0, 0, 16'h0F0F);
        run_txn(1, 0, 16'h0028, 16'h0000, 1, TIMEOUT,    0, 0, 0, 16'h0000);
        run_txn(1, 0, 16'h0011, 16'h0000, 0, 0,          0, 0, 0, 16'h0000);
        run_txn(1, 0, 16'h0030, 16'h0000, 0, 1,          0, 0, 0, 16'h5A5A);
        run_txn(0, 1, 16'h0034, 16'hAAAA, 2, 0,          0, 1, 0, 16'h0000);
        run_txn(1, 0, 16'h0038, 16'h0000, 1, 2,          0, 0, 1, 16'h7777);
        run_txn(1, 0, 16'h003C, 16'h0000, 0, 0,          1, 0, 0, 16'h0000);
        run_txn(1, 1, 16'h0050, 16'h4321, 0, 0,          0, 0, 0, 16'h1111);
        run_txn(0, 0, 16'h0060, 16'h0000, 0, 0,          0, 0, 0, 16'h0000);

        for (int i = 0; i < 200; i++) begin
            kind = $urandom_range(0, 11);
            t    = $urandom_range(0, 2);
            a    = DW'($urandom) & 16'hFFFE;
            if (kind == 0) a = a | 16'h0001;
            nb   = $urandom_range(0, 3);
            dly  = ($urandom_range(0, 9) == 0) ? TIMEOUT : $urandom_range(0, 4);
            run_txn((t != 1) && (kind != 2), (t != 0) && (kind != 2), a, DW'($urandom),
                    nb, dly, kind == 1, (nb > 0) && (kind == 3), $urandom_range(0, 5) == 0,
                    DW'($urandom));
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end

        repeat (3) @(posedge clk);
        #1;
        chk("sb_drain", 32'(q.size()), 32'd0);

        // Reset in the middle of WAIT, then a late completion pulse.
        mon_en       = 1'b0;
        mem_read_in  = 1'b1;
        addr_in      = 16'h0070;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        clear_req();
        @(posedge clk);
        #1;
        chk("pre_rst_stall", 32'(stall_out), 32'd1);
        chk("pre_rst_err", 32'(err_out), 32'(m_err));
        rst = 1'b1;
        #1;
        chk("mid_rst_mem_en", 32'(mem_en), 32'd0);
        chk("mid_rst_mem_wr", 32'(mem_wr), 32'd0);
        chk("mid_rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("mid_rst_mem_wdata", 32'(mem_wdata), 32'd0);
        chk("mid_rst_stall", 32'(stall_out), 32'd0);
        chk("mid_rst_rdata", 32'(rdata_out), 32'd0);
        chk("mid_rst_rvalid", 32'(rdata_valid), 32'd0);
        chk("mid_rst_err", 32'(err_out), 32'd0);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        mem_done  = 1'b1;
        mem_rdata = 16'hDEAD;
        @(posedge clk);
        #1;
        mem_done = 1'b0;
        @(negedge clk);
        chk("late_done_rdata", 32'(rdata_out), 32'd0);
        chk("late_done_rvalid", 32'(rdata_valid), 32'd0);
        chk("late_done_err", 32'(err_out), 32'd0);
        chk("late_done_stall", 32'(stall_out), 32'd0);
        chk("late_done_mem_en", 32'(mem_en), 32'd0);

        m_rdata    = '0;
        m_err      = 1'b0;
        prev_stall = 1'b0;
        run_stall  = 0;
        run_en     = 0;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        run_txn(1, 0, 16'h0080, 16'h0000, 1, 0, 0, 0, 0, 16'hC0DE);
        repeat (2) @(posedge clk);
        #1;
        chk("sb_drain_final", 32'(q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
